// File: rtl/riscv_pkg.sv
// Shared RISCV32I definitions: machine width, core opcodes/functs, NOP encoding,
// memory responder state encoding and a byte-lane merge helper.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_e;

    // Byte-lane merge: lanes with strb set take new data, others keep old.
    function automatic logic [XLEN-1:0] strb_merge(
        input logic [XLEN-1:0]   old_word,
        input logic [XLEN-1:0]   new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [XLEN-1:0] w;
        w = old_word;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Fetch/load/store bus between the RISCV32I core (master) and the memory responder (slave).
interface riscv_mem_responder_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]   instr_addr;
    logic [XLEN-1:0]   instruction;
    logic              read_en;
    logic [XLEN-1:0]   read_addr;
    logic [XLEN-1:0]   read_data;
    logic              write_en;
    logic [XLEN-1:0]   write_addr;
    logic [XLEN-1:0]   write_data;
    logic [STRB_W-1:0] write_strb;
    logic              busy;
    logic              fault;

    modport master (
        output instr_addr, read_en, read_addr, write_en, write_addr, write_data, write_strb,
        input  instruction, read_data, busy, fault
    );

    modport slave (
        input  instr_addr, read_en, read_addr, write_en, write_addr, write_data, write_strb,
        output instruction, read_data, busy, fault
    );
endinterface

// File: rtl/riscv_mem_bank.sv
// Word RAM with one byte-strobed write port and two registered read ports
// that see a same-cycle write (write-first). Illegal reads load a fill word.
module riscv_mem_bank
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] RD0_RST     = '0,
    parameter logic [XLEN-1:0] RD1_RST     = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] widx,
    input  logic [XLEN-1:0]                wdata,
    input  logic [STRB_W-1:0]              wstrb,
    input  logic                           rd0_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd0_idx,
    input  logic                           rd0_ok,
    input  logic [XLEN-1:0]                rd0_fill,
    output logic [XLEN-1:0]                rd0_data,
    input  logic                           rd1_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd1_idx,
    input  logic                           rd1_ok,
    input  logic [XLEN-1:0]                rd1_fill,
    output logic [XLEN-1:0]                rd1_data
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rd0_word_c;
    logic [XLEN-1:0] rd1_word_c;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Forwarded read words: merge the in-flight store when it targets the same word.
    always_comb begin
        rd0_word_c = mem[rd0_idx];
        rd1_word_c = mem[rd1_idx];
        if (we && (widx == rd0_idx)) rd0_word_c = strb_merge(mem[rd0_idx], wdata, wstrb);
        if (we && (widx == rd1_idx)) rd1_word_c = strb_merge(mem[rd1_idx], wdata, wstrb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd0_data <= RD0_RST;
            rd1_data <= RD1_RST;
        end else begin
            if (rd0_en) rd0_data <= rd0_ok ? rd0_word_c : rd0_fill;
            if (rd1_en) rd1_data <= rd1_ok ? rd1_word_c : rd1_fill;
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory responder for the RISCV32I core: clears the RAM after reset, then serves
// fetch/load/store with one-cycle latency and a sticky illegal-access fault.
module riscv_mem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    riscv_mem_responder_if.slave  bus
);

    localparam int unsigned IDXW = $clog2(DEPTH_WORDS);
    typedef logic [IDXW-1:0] idx_t;

    function automatic logic addr_ok(input logic [XLEN-1:0] a);
        return (a[1:0] == 2'b00) && (a[XLEN-1:IDXW+2] == '0);
    endfunction

    function automatic idx_t addr_idx(input logic [XLEN-1:0] a);
        return a[IDXW+1:2];
    endfunction

    mem_state_e        state, state_next;
    idx_t              clr_cnt;
    logic              busy_q;
    logic              fault_q;
    logic              f_ok_c, r_ok_c, w_ok_c;
    logic              fault_set_c;
    logic              mem_we_c;
    idx_t              mem_widx_c;
    logic [XLEN-1:0]   mem_wdata_c;
    logic [STRB_W-1:0] mem_wstrb_c;
    logic              rd0_en_c, rd1_en_c;

    assign f_ok_c = addr_ok(bus.instr_addr);
    assign r_ok_c = addr_ok(bus.read_addr);
    assign w_ok_c = addr_ok(bus.write_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_cnt == idx_t'(DEPTH_WORDS - 1)) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // RAM port control: clear writes while busy, core traffic once ready.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_widx_c  = '0;
        mem_wdata_c = '0;
        mem_wstrb_c = '0;
        rd0_en_c    = 1'b0;
        rd1_en_c    = 1'b0;
        fault_set_c = 1'b0;
        case (state)
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_widx_c  = clr_cnt;
                mem_wstrb_c = '1;
            end
            READY: begin
                mem_we_c    = bus.write_en && w_ok_c;
                mem_widx_c  = addr_idx(bus.write_addr);
                mem_wdata_c = bus.write_data;
                mem_wstrb_c = bus.write_strb;
                rd0_en_c    = 1'b1;
                rd1_en_c    = bus.read_en;
                fault_set_c = !f_ok_c || (bus.read_en && !r_ok_c) || (bus.write_en && !w_ok_c);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
            busy_q  <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            if (state == CLEAR) clr_cnt <= clr_cnt + idx_t'(1);
            busy_q <= (state_next == CLEAR);
            if (fault_set_c) fault_q <= 1'b1;
        end
    end

    riscv_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .RD0_RST     (NOP_WORD),
        .RD1_RST     ('0)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (mem_we_c),
        .widx     (mem_widx_c),
        .wdata    (mem_wdata_c),
        .wstrb    (mem_wstrb_c),
        .rd0_en   (rd0_en_c),
        .rd0_idx  (addr_idx(bus.instr_addr)),
        .rd0_ok   (f_ok_c),
        .rd0_fill (NOP_WORD),
        .rd0_data (bus.instruction),
        .rd1_en   (rd1_en_c),
        .rd1_idx  (addr_idx(bus.read_addr)),
        .rd1_ok   (r_ok_c),
        .rd1_fill ('0),
        .rd1_data (bus.read_data)
    );

    assign bus.busy  = busy_q;
    assign bus.fault = fault_q;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed + random bench for riscv_mem_responder (DEPTH_WORDS=16) against a word-array model.
module tb_riscv_mem_responder;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    riscv_mem_responder_if bus ();

    riscv_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mdl [DEPTH];
    int          clear_left;
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
    logic        exp_busy;
    logic        exp_fault;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instruction"}, bus.instruction, exp_instr);
        chk({tag, ".read_data"}, bus.read_data, exp_rdata);
        chk({tag, ".busy"}, {31'b0, bus.busy}, {31'b0, exp_busy});
        chk({tag, ".fault"}, {31'b0, bus.fault}, {31'b0, exp_fault});
    endtask

    // One clock of traffic; the model applies the store first so reads see the new word.
    task automatic step(input string tag, input logic [31:0] ia, input logic re, input logic [31:0] ra,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] w;
        bus.instr_addr = ia;
        bus.read_en    = re;
        bus.read_addr  = ra;
        bus.write_en   = we;
        bus.write_addr = wa;
        bus.write_data = wd;
        bus.write_strb = ws;
        if (clear_left > 0) begin
            clear_left--;
            exp_busy = (clear_left > 0);
        end else begin
            if (we) begin
                if (legal(wa)) begin
                    w = mdl[wa / 4];
                    for (int i = 0; i < 4; i++) if (ws[i]) w[8*i +: 8] = wd[8*i +: 8];
                    mdl[wa / 4] = w;
                end else exp_fault = 1'b1;
            end
            if (legal(ia)) exp_instr = mdl[ia / 4];
            else begin
                exp_instr = NOP;
                exp_fault = 1'b1;
            end
            if (re) begin
                if (legal(ra)) exp_rdata = mdl[ra / 4];
                else begin
                    exp_rdata = 32'h0;
                    exp_fault = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_left = DEPTH;
        for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
        exp_instr = NOP;
        exp_rdata = 32'h0;
        exp_busy  = 1'b1;
        exp_fault = 1'b0;
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, wa, wd;
        logic [3:0]  ws;
        logic        re, we;
        passed = 0;
        total  = 0;
        rst = 1'b0;
        bus.instr_addr = '0;
        bus.read_en    = 1'b0;
        bus.read_addr  = '0;
        bus.write_en   = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.write_strb = '0;
        #3;
        do_reset();

        // Clear sequence: busy for exactly DEPTH cycles, NOP throughout, then zeroed RAM.
        for (int i = 0; i < int'(DEPTH); i++) idle("clear");
        idle("first_fetch");

        step("store_full", 32'h0, 1'b0, 32'h0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
        step("load_full", 32'h0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0);

        step("prefill", 32'h0, 1'b0, 32'h0, 1'b1, 32'h4, 32'hAAAA_AAAA, 4'hF);
        step("fwd_merge", 32'h4, 1'b1, 32'h4, 1'b1, 32'h4, 32'h1122_3344, 4'b0101);
        step("strb_zero", 32'h4, 1'b1, 32'h4, 1'b1, 32'h4, 32'h5555_5555, 4'h0);

        // Random legal traffic, including same-word collisions between ports.
        for (int n = 0; n < 150; n++) begin
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ra = 32'($urandom_range(0, DEPTH - 1)) * 4;
            wa = 32'($urandom_range(0, DEPTH - 1)) * 4;
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            step("random", 32'($urandom_range(0, DEPTH - 1)) * 4, re, ra, we, wa, wd, ws);
        end

        step("pre_word1", 32'h0, 1'b1, 32'h4, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF);
        step("misaligned_load", 32'h0, 1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 4'h0);
        step("oor_fetch", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) idle("fault_sticky");
        step("oor_store", 32'h0, 1'b0, 32'h0, 1'b1, 32'h44, 32'h1234_5678, 4'hF);
        step("word1_kept", 32'h4, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset mid-clear restarts the sequence; stores during busy are ignored.
        do_reset();
        for (int i = 0; i < 5; i++) idle("clear_a");
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i == 3) step("busy_store", 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 32'h1234_5678, 4'hF);
            else        idle("clear_b");
        end
        step("load_after_clear", 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
